// File: rtl/k2_pkg.sv
// Shared constants and helpers for the Kyber-style K2 butterfly datapath.
// Provides modulus q, K^2 factor, coefficient width and 2^-1 mod q helper.
package k2_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int K2_FACTOR = 169;
    localparam int COEF_W    = 12;
    localparam int HALF_Q    = 1665;

    typedef logic [COEF_W-1:0] coef_t;

    // Multiply by 2^-1 mod q: odd x maps to (x-1)/2 + (q+1)/2.
    function automatic coef_t k2_halve(coef_t x);
        coef_t h;
        h = {1'b0, x[COEF_W-1:1]};
        if (x[0]) begin
            h = h + coef_t'(HALF_Q);
        end
        return h;
    endfunction

endpackage

// File: rtl/k2_red.sv
// Combinational K2RED: 24-bit product to 169*x mod q, fully reduced.
// Two K-RED folds (13*low - high) followed by one signed correction.
module k2_red
    import k2_pkg::*;
(
    input  logic [2*COEF_W-1:0] x_i,
    output logic [COEF_W-1:0]   r_o
);

    localparam int K = 13;

    logic [11:0] lo1_m;
    logic [11:0] lo2_m;
    logic [17:0] c1;
    logic [13:0] c2;

    // Fold twice; c1 in -65535..3315, c2 in -12..3571, then correct once.
    always_comb begin
        lo1_m = 12'(x_i[7:0]) * 12'(K);
        c1    = {6'd0, lo1_m} - {2'd0, x_i[23:8]};
        lo2_m = 12'(c1[7:0]) * 12'(K);
        c2    = {2'd0, lo2_m} - {{4{c1[17]}}, c1[17:8]};
        if (c2[13]) begin
            r_o = 12'(c2 + 14'(KYBER_Q));
        end else if (c2 >= 14'(KYBER_Q)) begin
            r_o = 12'(c2 - 14'(KYBER_Q));
        end else begin
            r_o = c2[11:0];
        end
    end

endmodule

// File: rtl/k2_gs_butterfly.sv
// Gentleman-Sande inverse butterfly, 3-stage pipeline with global stall.
// Define K2_GS_HALVE_EN to scale both outputs by 2^-1 mod q in S3.
module k2_gs_butterfly
    import k2_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    input  logic [11:0]      in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_u,
    output logic [11:0]      out_v,
    output logic [TAG_W-1:0] out_tag
);

    logic             advance;

    logic             s1_vld_q;
    logic [11:0]      s1_u_q;
    logic [11:0]      s1_d_q;
    logic [11:0]      s1_w_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_vld_q;
    logic [23:0]      s2_p_q;
    logic [11:0]      s2_u_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s3_vld_q;
    logic [11:0]      s3_u_q;
    logic [11:0]      s3_v_q;
    logic [TAG_W-1:0] s3_tag_q;

    logic [12:0]      sum_m;
    logic [12:0]      dif_m;
    logic [11:0]      s1_u_d;
    logic [11:0]      s1_d_d;
    logic [23:0]      s2_p_d;
    logic [11:0]      red_v;
    logic [11:0]      s3_u_d;
    logic [11:0]      s3_v_d;

    // Whole pipe moves together unless the output is held.
    assign advance  = !s3_vld_q || out_ready;
    assign in_ready = advance;

    // Modular add and subtract of the incoming coefficients.
    always_comb begin
        sum_m = {1'b0, in_a} + {1'b0, in_b};
        dif_m = {1'b0, in_a} - {1'b0, in_b};
        if (sum_m >= 13'(KYBER_Q)) begin
            s1_u_d = 12'(sum_m - 13'(KYBER_Q));
        end else begin
            s1_u_d = sum_m[11:0];
        end
        if (dif_m[12]) begin
            s1_d_d = 12'(dif_m + 13'(KYBER_Q));
        end else begin
            s1_d_d = dif_m[11:0];
        end
        s2_p_d = {12'd0, s1_d_q} * {12'd0, s1_w_q};
    end

    k2_red u_red (
        .x_i (s2_p_q),
        .r_o (red_v)
    );

    // Optional 2^-1 scaling applied to both outputs before S3.
    always_comb begin
`ifdef K2_GS_HALVE_EN
        s3_u_d = k2_halve(s2_u_q);
        s3_v_d = k2_halve(red_v);
`else
        s3_u_d = s2_u_q;
        s3_v_d = red_v;
`endif
    end

    // S1: sum, difference, twiddle and tag; bubble when no input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_u_q   <= '0;
            s1_d_q   <= '0;
            s1_w_q   <= '0;
            s1_tag_q <= '0;
        end else if (advance) begin
            s1_vld_q <= in_valid;
            s1_u_q   <= s1_u_d;
            s1_d_q   <= s1_d_d;
            s1_w_q   <= in_w;
            s1_tag_q <= in_tag;
        end
    end

    // S2: full 24-bit product with u and tag riding along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_p_q   <= '0;
            s2_u_q   <= '0;
            s2_tag_q <= '0;
        end else if (advance) begin
            s2_vld_q <= s1_vld_q;
            s2_p_q   <= s2_p_d;
            s2_u_q   <= s1_u_q;
            s2_tag_q <= s1_tag_q;
        end
    end

    // S3: reduced results, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q <= 1'b0;
            s3_u_q   <= '0;
            s3_v_q   <= '0;
            s3_tag_q <= '0;
        end else if (advance) begin
            s3_vld_q <= s2_vld_q;
            s3_u_q   <= s3_u_d;
            s3_v_q   <= s3_v_d;
            s3_tag_q <= s2_tag_q;
        end
    end

    assign out_valid = s3_vld_q;
    assign out_u     = s3_u_q;
    assign out_v     = s3_v_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_k2_gs_butterfly.sv
// Directed and random bench for k2_gs_butterfly.
// Honours K2_GS_HALVE_EN for expected values.
module tb_k2_gs_butterfly;

    localparam int TAG_W = 8;
    localparam int Q     = 3329;

`ifdef K2_GS_HALVE_EN
    localparam int EA_U = 4,    EA_V = 169;
    localparam int EB_U = 1665, EB_V = 1580;
    localparam int EC_U = 3328, EC_V = 0;
    localparam int ED_U = 150,  ED_V = 1027;
`else
    localparam int EA_U = 8,    EA_V = 338;
    localparam int EB_U = 1,    EB_V = 3160;
    localparam int EC_U = 3327, EC_V = 0;
    localparam int ED_U = 300,  ED_V = 2054;
`endif

    typedef struct {
        int u;
        int v;
        int tag;
        int cyc;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [11:0]      in_a      = '0;
    logic [11:0]      in_b      = '0;
    logic [11:0]      in_w      = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [11:0]      out_u;
    logic [11:0]      out_v;
    logic [TAG_W-1:0] out_tag;

    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    bit   rdy_rand  = 1'b0;
    bit   rdy_force = 1'b1;
    bit   chk_lat   = 1'b0;
    exp_t q[$];

    k2_gs_butterfly #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u     (out_u),
        .out_v     (out_v),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mdl_u(input int a, input int b);
        int s;
        s = (a + b) % Q;
`ifdef K2_GS_HALVE_EN
        s = (s * 1665) % Q;
`endif
        return s;
    endfunction

    function automatic int mdl_v(input int a, input int b, input int w);
        int d;
        int v;
        d = (a - b + Q) % Q;
        v = ((d * w) % Q) * 169 % Q;
`ifdef K2_GS_HALVE_EN
        v = (v * 1665) % Q;
`endif
        return v;
    endfunction

    // Scoreboard: every delivered result must match the oldest pending one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_u", int'(out_u), e.u);
                check("out_v", int'(out_v), e.v);
                check("out_tag", int'(out_tag), e.tag);
                if (chk_lat) check("latency", cyc - e.cyc, 3);
            end
        end
    end

    task automatic send(input int a, input int b, input int w,
                        input int tag, input int eu, input int ev);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        in_a     = 12'(a);
        in_b     = 12'(b);
        in_w     = 12'(w);
        in_tag   = TAG_W'(tag);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.u = eu;
                e.v = ev;
                e.tag = tag;
                e.cyc = cyc;
                q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", int'(acc), 1);
    endtask

    task automatic sendm();
        int a;
        int b;
        int w;
        a = $urandom_range(0, Q - 1);
        b = $urandom_range(0, Q - 1);
        w = $urandom_range(0, Q - 1);
        send(a, b, w, $urandom_range(0, 255), mdl_u(a, b), mdl_v(a, b, w));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        check("drain", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_u", int'(out_u), 0);
        check("rst_out_v", int'(out_v), 0);
        check("rst_out_tag", int'(out_tag), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        chk_lat = 1'b1;
        send(5, 3, 1, 'h2A, EA_U, EA_V);
        drain();
        send(0, 1, 1, 1, EB_U, EB_V);
        send(3328, 3328, 77, 2, EC_U, EC_V);
        drain();
        chk_lat = 1'b0;

        rdy_force = 1'b0;
        send(5, 3, 1, 11, EA_U, EA_V);
        send(0, 1, 1, 12, EB_U, EB_V);
        send(3328, 3328, 77, 13, EC_U, EC_V);
        in_a     = 12'd100;
        in_b     = 12'd200;
        in_w     = 12'd5;
        in_tag   = 8'd14;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_hold_u", int'(out_u), EA_U);
            check("bp_hold_v", int'(out_v), EA_V);
            check("bp_hold_tag", int'(out_tag), 11);
            @(posedge clk);
            #1;
        end
        rdy_force = 1'b1;
        send(100, 200, 5, 14, ED_U, ED_V);
        drain();

        chk_lat = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 50; i++) sendm();
        check("burst_cycles", cyc - t0, 50);
        drain();
        chk_lat = 1'b0;

        for (int i = 0; i < 4; i++) sendm();
        check("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_u", int'(out_u), 0);
        check("mid_rst_v", int'(out_v), 0);
        check("mid_rst_tag", int'(out_tag), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sendm();
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
